// File: rtl/load_store_unit.sv
// Sequential load/store engine between the CPU datapath and a valid/ready
// data-memory bus. It steers byte lanes, extends loads and times out slow reads.
module load_store_unit #(
  parameter int XLEN         = 32,
  parameter int READ_TIMEOUT = 255,
  parameter int LS_SEL_WIDTH = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_N,
  input  logic                  i_Start,
  input  logic [LS_SEL_WIDTH:0] i_Load_Store_Type,
  input  logic [XLEN-1:0]       i_Addr,
  input  logic [XLEN-1:0]       i_Store_Data,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [XLEN-1:0]       o_Load_Data,
  output logic                  o_Misaligned,
  output logic                  o_Bus_Error,
  output logic                  o_Mem_Req,
  input  logic                  i_Mem_Ready,
  output logic [XLEN-1:0]       o_Mem_Addr,
  output logic                  o_Mem_Write_Enable,
  output logic [3:0]            o_Mem_Byte_Enable,
  output logic [XLEN-1:0]       o_Mem_Write_Data,
  input  logic                  i_Mem_Read_Valid,
  input  logic [XLEN-1:0]       i_Mem_Read_Data
);
  localparam int TW = LS_SEL_WIDTH + 1;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_NONE               = TW'(0);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE          = TW'(1);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF          = TW'(2);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_WORD          = TW'(3);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE_UNSIGNED = TW'(4);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF_UNSIGNED = TW'(5);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_BYTE         = TW'(6);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_HALF         = TW'(7);
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_WORD         = TW'(8);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

  state_t                state_reg;
  logic [LS_SEL_WIDTH:0] type_reg;
  logic [1:0]            off_reg;
  logic [7:0]            cnt_reg;

  logic            dec_load, dec_store, dec_misaligned;
  logic [1:0]      dec_size;
  logic [3:0]      dec_be;
  logic [XLEN-1:0] dec_wdata;
  logic [15:0]     lane;
  logic [XLEN-1:0] ext_data;

  // Request decode works straight off the start-cycle inputs; anything
  // unrecognised behaves like LS_TYPE_NONE.
  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_size  = 2'd0;
    case (i_Load_Store_Type)
      LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_BYTE_UNSIGNED: dec_load = 1'b1;
      LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_HALF_UNSIGNED: begin dec_load = 1'b1; dec_size = 2'd1; end
      LS_TYPE_LOAD_WORD:  begin dec_load = 1'b1;  dec_size = 2'd2; end
      LS_TYPE_STORE_BYTE: dec_store = 1'b1;
      LS_TYPE_STORE_HALF: begin dec_store = 1'b1; dec_size = 2'd1; end
      LS_TYPE_STORE_WORD: begin dec_store = 1'b1; dec_size = 2'd2; end
      default: ;
    endcase
    dec_misaligned = ((dec_size == 2'd1) && i_Addr[0]) ||
                     ((dec_size == 2'd2) && (i_Addr[1:0] != 2'b00));
    case (dec_size)
      2'd0: begin
        dec_be    = 4'b0001 << i_Addr[1:0];
        dec_wdata = {4{i_Store_Data[7:0]}};
      end
      2'd1: begin
        dec_be    = i_Addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{i_Store_Data[15:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = i_Store_Data;
      end
    endcase
  end

  always_comb begin
    lane = 16'(i_Mem_Read_Data >> {off_reg, 3'b000});
    case (type_reg)
      LS_TYPE_LOAD_BYTE:          ext_data = {{24{lane[7]}}, lane[7:0]};
      LS_TYPE_LOAD_BYTE_UNSIGNED: ext_data = {24'b0, lane[7:0]};
      LS_TYPE_LOAD_HALF:          ext_data = {{16{lane[15]}}, lane};
      LS_TYPE_LOAD_HALF_UNSIGNED: ext_data = {16'b0, lane};
      default:                    ext_data = i_Mem_Read_Data;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_reg          <= IDLE;
      type_reg           <= '0;
      off_reg            <= 2'b00;
      cnt_reg            <= 8'd0;
      o_Busy             <= 1'b0;
      o_Done             <= 1'b0;
      o_Load_Data        <= '0;
      o_Misaligned       <= 1'b0;
      o_Bus_Error        <= 1'b0;
      o_Mem_Req          <= 1'b0;
      o_Mem_Addr         <= '0;
      o_Mem_Write_Enable <= 1'b0;
      o_Mem_Byte_Enable  <= 4'b0000;
      o_Mem_Write_Data   <= '0;
    end else begin
      o_Done       <= 1'b0;
      o_Misaligned <= 1'b0;
      o_Bus_Error  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_Start) begin
            o_Busy      <= 1'b1;
            o_Load_Data <= '0;
            if (!(dec_load || dec_store) || dec_misaligned) begin
              o_Misaligned <= dec_misaligned && (dec_load || dec_store);
              o_Done       <= 1'b1;
              state_reg    <= DONE;
            end else begin
              type_reg           <= i_Load_Store_Type;
              off_reg            <= i_Addr[1:0];
              o_Mem_Addr         <= {i_Addr[XLEN-1:2], 2'b00};
              o_Mem_Byte_Enable  <= dec_be;
              o_Mem_Write_Data   <= dec_wdata;
              o_Mem_Write_Enable <= dec_store;
              o_Mem_Req          <= 1'b1;
              state_reg          <= REQ;
            end
          end
        end
        REQ: begin
          if (i_Mem_Ready) begin
            o_Mem_Req <= 1'b0;
            cnt_reg   <= 8'd0;
            if (o_Mem_Write_Enable) begin
              o_Done    <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // Read data arriving on the last allowed cycle still beats the timeout.
          if (i_Mem_Read_Valid) begin
            o_Load_Data <= ext_data;
            o_Done      <= 1'b1;
            state_reg   <= DONE;
          end else if (cnt_reg == 8'(READ_TIMEOUT)) begin
            o_Load_Data <= '0;
            o_Bus_Error <= 1'b1;
            o_Done      <= 1'b1;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          o_Busy    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential data-memory access engine between the CPU datapath and the data-memory bus. It executes the load/store operation selected by the decoded load/store type and the ALU-computed address, and drives a valid/ready request channel toward memory. It handles byte-lane generation, store-data replication and load sign/zero extension, and reports misaligned accesses and read timeouts. The pipeline holds the instruction while `o_Busy` is high and consumes the result on `o_Done`.

## Interface
- `XLEN`, 32: data and address width. Only 32 is supported.
- `READ_TIMEOUT`, 255: maximum number of cycles spent waiting for read data before the read is aborted. Legal range is 1–255.
- `i_Clock` input 1: the single clock. All logic is rising-edge.
- `i_Reset_N` input 1: reset, asynchronous, active-low.
- `i_Start` input 1: one-cycle request strobe. Sampled only in IDLE.
- `i_Load_Store_Type` input [LS_SEL_WIDTH:0]: `LS_TYPE_*` encoding from memory.vh. Sampled with `i_Start`.
- `i_Addr` input 32: byte address (ALU result). Sampled with `i_Start`.
- `i_Store_Data` input 32: rs2 value. Sampled with `i_Start`.
- `o_Busy` input/output: output 1. High in every state except IDLE.
- `o_Done` output 1: one-cycle completion pulse.
- `o_Load_Data` output 32: extended load result.
- `o_Misaligned` output 1: pulse coincident with `o_Done`.
- `o_Bus_Error` output 1: pulse coincident with `o_Done` on read timeout.
- `o_Mem_Req` output 1: request valid.
- `i_Mem_Ready` input 1: request accepted.
- `o_Mem_Addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `o_Mem_Write_Enable` output 1: 1 for a store request.
- `o_Mem_Byte_Enable` output 4: byte lanes.
- `o_Mem_Write_Data` output 32: lane-replicated store data.
- `i_Mem_Read_Valid` input 1: read response valid.
- `i_Mem_Read_Data` input 32: read response word.

## Operation
- **FSM states:** IDLE, REQ, WAIT_RD, DONE.
- **IDLE:**
  - `i_Start` with `LS_TYPE_NONE`: go to DONE. No bus activity.
  - `i_Start` with a misaligned access: set misaligned flag, go to DONE. No bus activity.
    - Half-word is misaligned if `addr[0]=1`.
    - Word is misaligned if `addr[1:0]≠0`.
  - Any other `i_Start`: latch type, address and data, go to REQ.
- **REQ:**
  - `o_Mem_Req=1`. All `o_Mem_*` outputs are stable until handshake.
  - On a handshake (`i_Mem_Ready=1`): a store goes to DONE, a load goes to WAIT_RD.
- **WAIT_RD:**
  - On `i_Mem_Read_Valid`: capture the extended data, go to DONE.
  - Otherwise: count cycles. If the count reaches `READ_TIMEOUT`, set bus error, force load data to 0, go to DONE.
- **DONE:** `o_Done=1` for one cycle, then go to IDLE.
- **Byte enables and store data** (offset `o = addr[1:0]`):
  - Byte: BE = `4'b0001<<o`, data = `{4{d[7:0]}}`.
  - Half: BE = `4'b0011` if `o=0`, `4'b1100` if `o=2`; data = `{2{d[15:0]}}`.
  - Word: BE = `4'b1111`, data = d.
  - Loads: BE is still driven with the same lane pattern; `o_Mem_Write_Enable=0`.
- **Load extraction:** `lane = rdata >> (8*o)`.
  - `LOAD_BYTE` sign-extends `lane[7:0]`; `LOAD_BYTE_UNSIGNED` zero-extends it.
  - `LOAD_HALF` sign-extends `lane[15:0]`; `LOAD_HALF_UNSIGNED` zero-extends it.
  - `LOAD_WORD` passes `rdata` through.
- **`o_Load_Data` holding:** held from DONE until the next accepted `i_Start`. It is 0 after a store, NONE, misaligned or timeout.
- **Ignored inputs:**
  - `i_Start` is ignored whenever `o_Busy=1`.
  - `i_Mem_Read_Valid` is ignored outside WAIT_RD.

## Timing
- **Reset:** while `i_Reset_N=0`, all outputs are 0 asynchronously and the state is IDLE. This includes `o_Mem_Req`, `o_Busy`, `o_Done`, `o_Load_Data`, the flags, addr, BE and wdata.
- **Reset mid-transaction:** abandons the transaction. A later stray `i_Mem_Read_Valid` has no effect.
- **Registered outputs:** every output is registered; no combinational path from inputs.
- **Store latency** (`i_Start` at edge 0, zero-wait memory):
  - `o_Mem_Req` is high in cycle 1; `i_Mem_Ready` is high in cycle 1.
  - `o_Done` is high in cycle 2.
- **Load latency** (zero-wait memory):
  - Earliest `i_Mem_Read_Valid` is in cycle 2.
  - `o_Done` with data is high in cycle 3.
  - Read valid asserted in the same cycle as the handshake is not accepted.
- **Misaligned/NONE:** `o_Done` is high in cycle 1.
- **Wait states:** each cycle `i_Mem_Ready` is low adds one cycle; each cycle without read valid adds one cycle.
- **Timeout:** the counter starts at 0 on entering WAIT_RD. `o_Done` and `o_Bus_Error` rise exactly `READ_TIMEOUT+1` cycles after entry.
- **Valid and timeout on the same cycle:** the data wins and no error is flagged.
- **Back-to-back:** `i_Start` in the cycle after `o_Done` is accepted.

## Test plan
- **Word round trip:** store word `0xDEADBEEF` to `0x100`, then load word from `0x100` → BE `1111`, addr `0x100`; `o_Load_Data=0xDEADBEEF`; load `o_Done` 3 cycles after `i_Start`.
- **Byte store:** store byte `0x5A` to `0x103` → BE `1000`, wdata `0x5A5A5A5A`, `o_Mem_Addr=0x100`.
- **Signed vs unsigned loads:** memory word `0x80FF7F01`.
  - `LOAD_BYTE` @`0x102` → `0xFFFFFFFF`.
  - `LOAD_BYTE_UNSIGNED` @`0x103` → `0x00000080`.
  - `LOAD_HALF` @`0x102` → `0xFFFF80FF`.
  - `LOAD_HALF_UNSIGNED` @`0x100` → `0x00007F01`.
- **Misaligned:** `LOAD_WORD` @`0x102` and `STORE_HALF` @`0x101` → `o_Misaligned` and `o_Done` in cycle 1, `o_Mem_Req` never asserted.
- **Back-pressure and timeout:** hold `i_Mem_Ready` low 5 cycles → `o_Mem_Req` and outputs stable, `o_Done` delayed by 5. With `READ_TIMEOUT=4` and no read valid → `o_Bus_Error` with `o_Done` 5 cycles after WAIT_RD entry, data 0.
- **Reset mid-op:** drop `i_Reset_N` in WAIT_RD → outputs 0 immediately. A subsequent `i_Mem_Read_Valid` produces no `o_Done`.
